// File: rtl/t_state_sequencer.sv
// 6502 T-state sequencer: one-hot timing state, instruction register fetch and
// interrupt/reset BRK substitution feeding the random-logic control decoders.
module t_state_sequencer #(
    parameter logic [7:0]  BRK_OPCODE = 8'h00,
    parameter int unsigned MAX_T      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [7:0]       data_in,
    input  logic             last_cycle,
    input  logic             nmi,
    input  logic             irq,
    input  logic             i_flag,
    output logic [MAX_T:0]   T,
    output logic [MAX_T:0]   nextT,
    output logic [7:0]       OP,
    output logic [7:0]       nextOP,
    output logic [7:0]       prevOP,
    output logic [2:0]       activeInt,
    output logic             sync,
    output logic             seq_err
);

    localparam logic [MAX_T:0] TSt0 = (MAX_T+1)'(1);
    localparam logic [MAX_T:0] TSt1 = (MAX_T+1)'(2);
    localparam logic [MAX_T:0] TSt2 = (MAX_T+1)'(4);

    localparam logic [2:0] IntNone  = 3'b000;
    localparam logic [2:0] IntIrq   = 3'b001;
    localparam logic [2:0] IntNmi   = 3'b010;
    localparam logic [2:0] IntReset = 3'b100;

    logic           nmi_q;
    logic           nmi_latch;
    logic           nmi_edge;
    logic [MAX_T:0] step_t;
    logic           overflow;
    logic           fetch;
    logic           sel_reset;
    logic           sel_nmi;
    logic           sel_irq;
    logic           int_any;
    logic           end_brk;
    logic [2:0]     int_next;

    // Free-running successor of T, before rdy/rst gating.
    always_comb begin
        step_t   = T;
        overflow = 1'b0;
        if (T[0]) begin
            step_t = TSt1;
        end else if (T[1]) begin
            step_t = TSt2;
        end else if (last_cycle) begin
            step_t = TSt1;
        end else if (T[MAX_T]) begin
            step_t   = TSt1;
            overflow = 1'b1;
        end else begin
            step_t = T << 1;
        end
    end

    always_comb begin
        nextT     = rst ? TSt0 : (rdy ? step_t : T);
        fetch     = rdy & T[1];
        nmi_edge  = nmi & ~nmi_q;
        sel_reset = activeInt[2];
        sel_nmi   = ~activeInt[2] & nmi_latch;
        sel_irq   = ~activeInt[2] & ~nmi_latch & irq & ~i_flag;
        int_any   = sel_reset | sel_nmi | sel_irq;
        nextOP    = T[1] ? (int_any ? BRK_OPCODE : data_in) : OP;
        // Closing edge of a BRK-forced sequence releases the interrupt code.
        end_brk   = rdy & ~T[0] & ~T[1] & last_cycle & (activeInt != IntNone);
        int_next  = IntNone;
        if (sel_reset)    int_next = IntReset;
        else if (sel_nmi) int_next = IntNmi;
        else if (sel_irq) int_next = IntIrq;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            T         <= TSt0;
            OP        <= BRK_OPCODE;
            prevOP    <= 8'h00;
            activeInt <= IntReset;
            nmi_q     <= 1'b0;
            nmi_latch <= 1'b0;
            seq_err   <= 1'b0;
            sync      <= 1'b0;
        end else begin
            nmi_q <= nmi;
            // A new edge wins over a clear in the same cycle.
            if (nmi_edge) begin
                nmi_latch <= 1'b1;
            end else if (fetch && sel_nmi) begin
                nmi_latch <= 1'b0;
            end
            if (rdy) begin
                T    <= step_t;
                sync <= step_t[1];
                if (overflow) begin
                    seq_err <= 1'b1;
                end
                if (T[1]) begin
                    prevOP    <= OP;
                    OP        <= nextOP;
                    activeInt <= int_next;
                end else if (end_brk) begin
                    activeInt <= IntNone;
                end
            end
        end
    end

endmodule

// File: tb/tb_t_state_sequencer.sv
// Directed bench for t_state_sequencer: reset, fetch, stall, NMI, IRQ masking and
// T-overflow scenarios with hand-computed expectations.
module tb_t_state_sequencer;

    logic       clk = 1'b0;
    logic       rst, rdy, last_cycle, nmi, irq, i_flag;
    logic [7:0] data_in;
    logic [6:0] T, nextT;
    logic [7:0] OP, nextOP, prevOP;
    logic [2:0] activeInt;
    logic       sync, seq_err;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [6:0] T0 = 7'b0000001;
    localparam logic [6:0] T1 = 7'b0000010;
    localparam logic [6:0] T2 = 7'b0000100;
    localparam logic [6:0] T3 = 7'b0001000;
    localparam logic [6:0] T4 = 7'b0010000;
    localparam logic [6:0] T5 = 7'b0100000;
    localparam logic [6:0] T6 = 7'b1000000;

    t_state_sequencer dut (
        .clk(clk), .rst(rst), .rdy(rdy), .data_in(data_in), .last_cycle(last_cycle),
        .nmi(nmi), .irq(irq), .i_flag(i_flag), .T(T), .nextT(nextT), .OP(OP),
        .nextOP(nextOP), .prevOP(prevOP), .activeInt(activeInt), .sync(sync),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; data_in = 8'hA9; last_cycle = 1'b0;
        nmi = 1'b0; irq = 1'b0; i_flag = 1'b1;
        repeat (3) step();
        vectors++;
        if (T !== T0 || OP !== 8'h00 || prevOP !== 8'h00 || activeInt !== 3'b100 ||
            seq_err !== 1'b0 || sync !== 1'b0 || nextT !== T0) begin
            miscompares++;
            $display("FAIL reset_state: T=%b OP=%h prevOP=%h int=%b err=%b sync=%b nextT=%b, want T0 00 00 100 0 0 T0",
                     T, OP, prevOP, activeInt, seq_err, sync, nextT);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (T !== T1 || sync !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_t1: T=%b sync=%b, want %b 1", T, sync, T1);
        end
        step();
        vectors++;
        if (T !== T2 || OP !== 8'h00 || activeInt !== 3'b100 || sync !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fetch: T=%b OP=%h int=%b sync=%b, want T2 00 100 0",
                     T, OP, activeInt, sync);
        end
        repeat (4) step();
        vectors++;
        if (T !== T6 || activeInt !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_t6: T=%b int=%b, want %b 100", T, activeInt, T6);
        end
        last_cycle = 1'b1;
        #1;
        vectors++;
        if (nextT !== T1) begin
            miscompares++;
            $display("FAIL reset_nextT: got %b want %b", nextT, T1);
        end
        step();
        last_cycle = 1'b0;
        vectors++;
        if (T !== T1 || activeInt !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_end: T=%b int=%b, want %b 000", T, activeInt, T1);
        end
    endtask

    task automatic test_two_cycle();
        data_in = 8'hE8;
        step();
        vectors++;
        if (T !== T2 || OP !== 8'hE8 || prevOP !== 8'h00) begin
            miscompares++;
            $display("FAIL two_cycle_e8: T=%b OP=%h prevOP=%h, want T2 E8 00", T, OP, prevOP);
        end
        last_cycle = 1'b1;
        step();
        last_cycle = 1'b0;
        data_in = 8'hC8;
        #1;
        vectors++;
        if (T !== T1 || nextOP !== 8'hC8) begin
            miscompares++;
            $display("FAIL two_cycle_t1: T=%b nextOP=%h, want T1 C8", T, nextOP);
        end
        step();
        vectors++;
        if (T !== T2 || OP !== 8'hC8 || prevOP !== 8'hE8) begin
            miscompares++;
            $display("FAIL two_cycle_c8: T=%b OP=%h prevOP=%h, want T2 C8 E8", T, OP, prevOP);
        end
    endtask

    task automatic test_stall();
        step();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (nextT !== T3) begin
                miscompares++;
                $display("FAIL stall_nextT[%0d]: got %b want %b", i, nextT, T3);
            end
            step();
            vectors++;
            if (T !== T3 || OP !== 8'hC8 || prevOP !== 8'hE8) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: T=%b OP=%h prevOP=%h, want T3 C8 E8",
                         i, T, OP, prevOP);
            end
        end
        rdy = 1'b1;
        step();
        vectors++;
        if (T !== T4) begin
            miscompares++;
            $display("FAIL stall_resume: T=%b want %b", T, T4);
        end
        last_cycle = 1'b1;
        step();
        last_cycle = 1'b0;
    endtask

    task automatic test_nmi();
        data_in = 8'hEA;
        step();
        step();
        nmi = 1'b1;
        step();
        last_cycle = 1'b1;
        step();
        last_cycle = 1'b0;
        #1;
        vectors++;
        if (T !== T1 || nextOP !== 8'h00) begin
            miscompares++;
            $display("FAIL nmi_pending: T=%b nextOP=%h, want T1 00", T, nextOP);
        end
        step();
        vectors++;
        if (OP !== 8'h00 || activeInt !== 3'b010 || prevOP !== 8'hEA) begin
            miscompares++;
            $display("FAIL nmi_taken: OP=%h int=%b prevOP=%h, want 00 010 EA",
                     OP, activeInt, prevOP);
        end
        last_cycle = 1'b1;
        step();
        last_cycle = 1'b0;
        vectors++;
        if (activeInt !== 3'b000) begin
            miscompares++;
            $display("FAIL nmi_release: int=%b want 000", activeInt);
        end
        data_in = 8'hA5;
        step();
        vectors++;
        if (OP !== 8'hA5 || activeInt !== 3'b000) begin
            miscompares++;
            $display("FAIL nmi_no_retrigger: OP=%h int=%b, want A5 000", OP, activeInt);
        end
        last_cycle = 1'b1;
        step();
        last_cycle = 1'b0;
        nmi = 1'b0;
    endtask

    task automatic test_irq();
        irq = 1'b1; i_flag = 1'b1; data_in = 8'h58;
        step();
        vectors++;
        if (OP !== 8'h58 || activeInt !== 3'b000) begin
            miscompares++;
            $display("FAIL irq_masked: OP=%h int=%b, want 58 000", OP, activeInt);
        end
        last_cycle = 1'b1;
        step();
        last_cycle = 1'b0;
        i_flag = 1'b0;
        step();
        vectors++;
        if (OP !== 8'h00 || activeInt !== 3'b001 || prevOP !== 8'h58) begin
            miscompares++;
            $display("FAIL irq_taken: OP=%h int=%b prevOP=%h, want 00 001 58",
                     OP, activeInt, prevOP);
        end
        last_cycle = 1'b1;
        step();
        last_cycle = 1'b0;
        irq = 1'b0; i_flag = 1'b1;
        vectors++;
        if (T !== T1 || activeInt !== 3'b000) begin
            miscompares++;
            $display("FAIL irq_release: T=%b int=%b, want %b 000", T, activeInt, T1);
        end
    endtask

    task automatic test_overflow();
        data_in = 8'h02;
        step();
        repeat (4) step();
        vectors++;
        if (T !== T6 || seq_err !== 1'b0 || nextT !== T1) begin
            miscompares++;
            $display("FAIL ovf_t6: T=%b err=%b nextT=%b, want T6 0 T1", T, seq_err, nextT);
        end
        step();
        vectors++;
        if (T !== T1 || seq_err !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_wrap: T=%b err=%b, want %b 1", T, seq_err, T1);
        end
        step();
        step();
        vectors++;
        if (T !== T3 || seq_err !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_sticky: T=%b err=%b, want %b 1", T, seq_err, T3);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (T !== T0 || seq_err !== 1'b0 || activeInt !== 3'b100 || OP !== 8'h00 ||
            nextT !== T0) begin
            miscompares++;
            $display("FAIL ovf_reset: T=%b err=%b int=%b OP=%h nextT=%b, want T0 0 100 00 T0",
                     T, seq_err, activeInt, OP, nextT);
        end
        step();
        rst = 1'b0;
        step();
        step();
        vectors++;
        if (T !== T2 || OP !== 8'h00 || activeInt !== 3'b100) begin
            miscompares++;
            $display("FAIL ovf_reseq: T=%b OP=%h int=%b, want T2 00 100", T, OP, activeInt);
        end
    endtask

    initial begin
        test_reset();
        test_two_cycle();
        test_stall();
        test_nmi();
        test_irq();
        test_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/t_state_sequencer.md
Name: t_state_sequencer

Overview:
- Upstream timing stage of the 6502 control path: generates the one-hot T-state, its one-cycle-ahead prediction, the instruction register (OP), the previous opcode (prevOP) and the active-interrupt code.
- These outputs drive the random-logic control decoders directly.
- Latches opcodes off the data bus at fetch.
- Substitutes BRK when an interrupt or reset sequence is pending.

Parameters:
- BRK_OPCODE, 8'h00, opcode forced into OP for interrupt/reset sequences.
- MAX_T, 6, highest legal T index; reaching it without last_cycle is a sequencing error.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rdy  input  1  high = advance; low = freeze all state (rst still acts).
- data_in  input  8  data bus; opcode sampled in T1.
- last_cycle  input  1  from decoder: current T is the final cycle of the instruction.
- nmi  input  1  non-maskable interrupt request, rising-edge sensitive.
- irq  input  1  interrupt request, level sensitive.
- i_flag  input  1  status I bit; 1 masks irq.
- T  output  7  one-hot T-state. Bit n = Tn; T0 is the post-reset hold state.
- nextT  output  7  combinational value T will take at the next edge.
- OP  output  8  current instruction register.
- nextOP  output  8  combinational value OP will take at the next edge.
- prevOP  output  8  opcode of the previous instruction.
- activeInt  output  3  100 = RESET, 010 = NMI, 001 = IRQ, 000 = none.
- sync  output  1  high while T == T1 (opcode fetch).
- seq_err  output  1  sticky T-overflow error flag.

Behaviour:
- Reset values (async, on rst):
  - T = T0 (7'b0000001), OP = BRK_OPCODE, prevOP = 8'h00.
  - activeInt = 3'b100, nmi edge latch = 0, seq_err = 0, sync = 0.
- T sequencing, on an edge with rdy = 1:
  - T0 -> T1.
  - T1 -> T2.
  - Tn (n ≥ 2) with last_cycle = 1 -> T1.
  - Tn (2 ≤ n < MAX_T) with last_cycle = 0 -> Tn+1.
  - T6 with last_cycle = 0 -> T1, and seq_err set. seq_err stays set until rst.
  - last_cycle is ignored in T0 and T1.
- rdy = 0: T, OP, prevOP, activeInt and seq_err all hold. The nmi edge detector still samples.
- nextT equals the transition above given current inputs. When rdy = 0, nextT = T. During rst, nextT = T0.
- Fetch: on the edge leaving T1 with rdy = 1:
  - prevOP <= OP.
  - OP <= nextOP.
  - nextOP = BRK_OPCODE if any interrupt is selected (below), else data_in.
  - Outside T1, nextOP = OP.
- prevOP is therefore valid from T2 onward for completing the prior instruction's register write-back.
- NMI edge detection:
  - nmi is registered every cycle; a 0->1 transition sets the nmi latch.
  - The latch is cleared when NMI is selected at fetch.
  - If a new edge and a clear occur in the same cycle, the latch is set.
- Interrupt selection at fetch, priority RESET > NMI > IRQ:
  - activeInt == 100: keep 100 and force BRK.
  - else if the nmi latch is set: activeInt <= 010, force BRK, clear latch.
  - else if irq & ~i_flag: activeInt <= 001, force BRK.
  - else: activeInt <= 000.
- activeInt clears to 000 on the edge where last_cycle = 1 in a BRK-forced sequence. A pending NMI is then taken at the next fetch.
- An irq deasserted before T1 is not taken; there is no latching of irq.
- Reset mid-instruction returns immediately to the reset values; the next fetch runs the RESET sequence.
- sync = (T == T1), registered alongside T.

Test Plan:
- Reset release:
  - Stimulus: rst high 3 cycles, then low; data_in = 8'hA9; last_cycle pulsed at T6.
  - Required: T goes T0 -> T1 -> T2…; activeInt = 100 and OP = 00 at T2; activeInt = 000 after the last_cycle edge.
- Two-cycle instruction:
  - Stimulus: after reset completes, data_in = 8'hE8 at T1; last_cycle = 1 at T2; then fetch 8'hC8.
  - Required: OP = E8 at T2; next T1; OP = C8 with prevOP = E8 at the following T2.
- Stall:
  - Stimulus: rdy low for 3 cycles during T3.
  - Required: T, OP, prevOP unchanged; nextT = T3 throughout; advances to T4 when rdy returns.
- NMI edge during instruction:
  - Stimulus: nmi 0->1 at T3 and held high.
  - Required: next fetch gives OP = 00, activeInt = 010. The following instruction fetches data_in normally (no re-trigger while nmi stays high).
- Masked IRQ:
  - Stimulus: irq = 1 with i_flag = 1 over a fetch.
  - Required: OP = data_in, activeInt = 000.
  - Then set i_flag = 0: the next fetch gives OP = 00, activeInt = 001.
- Overflow:
  - Stimulus: last_cycle held 0 from T2.
  - Required: T6 -> T1 with seq_err = 1 thereafter until rst.
